// File: rtl/cache_l1_inst_refill.sv
// Miss-refill engine for the two-way L1 instruction cache: issues a critical-word-first
// wrapping burst and streams each returned word into the selected way of the data RAM.
module cache_l1_inst_refill #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned RAM_AW     = 12
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [31:0]                            req_addr,
  input  logic                                   req_way,
  output logic                                   mem_rd_req,
  output logic [31:0]                            mem_rd_addr,
  input  logic                                   mem_rd_ack,
  input  logic                                   mem_rd_valid,
  input  logic [31:0]                            mem_rd_data,
  input  logic                                   mem_rd_last,
  output logic [RAM_AW-1:0]                      ram_addr,
  output logic [1:0]                             ram_en,
  output logic [1:0]                             ram_wen,
  output logic [31:0]                            ram_wdata,
  output logic                                   crit_valid,
  output logic [31:0]                            crit_data,
  output logic                                   refill_done,
  output logic                                   refill_way,
  output logic [RAM_AW-$clog2(LINE_WORDS)-1:0]   refill_index,
  output logic                                   refill_err
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = RAM_AW - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_e;

  state_e      state_q, state_d;
  logic [29:0] word_addr_q, word_addr_d;
  logic        way_q, way_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [OFF_W-1:0] crit_off;
  logic [IDX_W-1:0] line_index;
  logic [OFF_W-1:0] beat_off;
  logic             beat_fire;
  logic             unused_addr_bits;

  assign crit_off         = word_addr_q[OFF_W-1:0];
  assign line_index       = word_addr_q[OFF_W +: IDX_W];
  assign beat_off         = OFF_W'(crit_off + cnt_q);
  assign beat_fire        = (state_q == FILL) && mem_rd_valid;
  assign unused_addr_bits = ^req_addr[1:0];

  // Next-state: latch the miss in IDLE, count beats in FILL, track last-marker placement.
  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    way_d       = way_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          word_addr_d = req_addr[31:2];
          way_d       = req_way;
          cnt_d       = '0;
          err_d       = 1'b0;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (mem_rd_ack) state_d = FILL;
      end
      FILL: begin
        if (mem_rd_valid) begin
          cnt_d = OFF_W'(cnt_q + 1'b1);
          if (mem_rd_last != (cnt_q == LAST_BEAT)) err_d = 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      word_addr_q <= '0;
      way_q       <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      way_q       <= way_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign mem_rd_req   = (state_q == REQ);
  assign mem_rd_addr  = {word_addr_q, 2'b00};

  // RAM write port is driven in the beat cycle itself so the RAM captures on the same edge.
  assign ram_en       = {way_q, ~way_q} & {2{beat_fire}};
  assign ram_wen      = ram_en;
  assign ram_addr     = beat_fire ? {line_index, beat_off} : '0;
  assign ram_wdata    = beat_fire ? mem_rd_data : '0;

  assign crit_valid   = beat_fire && (cnt_q == '0);
  assign crit_data    = crit_valid ? mem_rd_data : '0;

  assign refill_done  = (state_q == DONE);
  assign refill_err   = (state_q == DONE) && err_q;
  assign refill_way   = way_q;
  assign refill_index = line_index;

endmodule

// File: tb/tb_cache_l1_inst_refill.sv
// Scoreboard bench for cache_l1_inst_refill: expected RAM writes are queued as beats are
// driven and retired by a monitor; per-scenario tasks check handshakes and completion.
module tb_cache_l1_inst_refill;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_way;
  logic [31:0] req_addr;
  logic        mem_rd_req, mem_rd_ack, mem_rd_valid, mem_rd_last;
  logic [31:0] mem_rd_addr, mem_rd_data;
  logic [11:0] ram_addr;
  logic [1:0]  ram_en, ram_wen;
  logic [31:0] ram_wdata;
  logic        crit_valid;
  logic [31:0] crit_data;
  logic        refill_done, refill_way, refill_err;
  logic [8:0]  refill_index;

  cache_l1_inst_refill dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_way(req_way),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .mem_rd_last(mem_rd_last),
    .ram_addr(ram_addr), .ram_en(ram_en), .ram_wen(ram_wen), .ram_wdata(ram_wdata),
    .crit_valid(crit_valid), .crit_data(crit_data),
    .refill_done(refill_done), .refill_way(refill_way), .refill_index(refill_index),
    .refill_err(refill_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic [1:0]  en;
  } wr_t;

  wr_t         exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          crit_seen = 0;
  int          done_seen = 0;
  logic [31:0] crit_last = '0;

  // Retire every observed RAM write against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (ram_en !== 2'b00) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL ram_write_unexpected: got en=%b addr=%h data=%h, required no write",
                   ram_en, ram_addr, ram_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if ({ram_en, ram_wen, ram_addr, ram_wdata} !== {e.en, e.en, e.addr, e.data}) begin
            fails++;
            $display("FAIL ram_write: got en=%b wen=%b addr=%h data=%h, required en=%b addr=%h data=%h",
                     ram_en, ram_wen, ram_addr, ram_wdata, e.en, e.addr, e.data);
          end
        end
      end
      if (crit_valid === 1'b1) begin
        crit_seen++;
        crit_last = crit_data;
        tests++;
        if (ram_en === 2'b00 || crit_data !== ram_wdata) begin
          fails++;
          $display("FAIL crit_with_write: got ram_en=%b crit_data=%h wdata=%h, required write of crit word",
                   ram_en, crit_data, ram_wdata);
        end
      end
      if (refill_done === 1'b1) done_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete miss: accept, REQ with optional ack delay, 8 beats with optional gaps, DONE.
  task automatic do_miss(input logic [31:0] a, input logic w, input int ack_dly,
                         input int gap, input int last_idx, input logic exp_err);
    logic [8:0]  idx;
    logic [2:0]  off;
    logic [31:0] base;
    int          c0;
    idx  = a[13:5];
    off  = a[4:2];
    base = $urandom;
    c0   = crit_seen;
    #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL accept_ready: got req_ready=%b, required 1", req_ready);
    end
    req_addr = a; req_way = w; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i <= ack_dly; i++) begin
      if (i < ack_dly) begin
        req_valid = 1'b1; req_addr = ~a; req_way = ~w;
      end else begin
        req_valid = 1'b0; req_addr = a; req_way = w; mem_rd_ack = 1'b1;
      end
      #1;
      tests++;
      if ({mem_rd_req, mem_rd_addr, req_ready} !== {1'b1, a[31:2], 2'b00, 1'b0}) begin
        fails++;
        $display("FAIL req_phase[%0d]: got req=%b addr=%h ready=%b, required req=1 addr=%h ready=0",
                 i, mem_rd_req, mem_rd_addr, req_ready, {a[31:2], 2'b00});
      end
      tick();
    end
    mem_rd_ack = 1'b0;
    for (int b = 0; b < 8; b++) begin
      repeat (gap) tick();
      mem_rd_valid = 1'b1;
      mem_rd_data  = base + 32'(b);
      mem_rd_last  = (b == last_idx);
      exp_q.push_back('{{idx, 3'(off + 3'(b))}, base + 32'(b), (w ? 2'b10 : 2'b01)});
      tick();
      mem_rd_valid = 1'b0; mem_rd_last = 1'b0; mem_rd_data = $urandom;
    end
    #1;
    tests++;
    if ({refill_done, refill_err, refill_way, refill_index} !== {1'b1, exp_err, w, idx}) begin
      fails++;
      $display("FAIL done_pulse: got done=%b err=%b way=%b idx=%h, required done=1 err=%b way=%b idx=%h",
               refill_done, refill_err, refill_way, refill_index, exp_err, w, idx);
    end
    tests++;
    if (crit_seen != c0 + 1 || crit_last !== base) begin
      fails++;
      $display("FAIL crit_word: got %0d pulses data=%h, required 1 pulse data=%h",
               crit_seen - c0, crit_last, base);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL writes_missing: got %0d writes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    tick();
    #1;
    tests++;
    if ({req_ready, refill_done, refill_err} !== 3'b100) begin
      fails++;
      $display("FAIL back_to_idle: got ready=%b done=%b err=%b, required ready=1 done=0 err=0",
               req_ready, refill_done, refill_err);
    end
  endtask

  task automatic test_reset();
    int d0;
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_way = 1'b0;
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_last = 1'b0; mem_rd_data = 32'hDEAD_BEEF;
    repeat (2) tick();
    tests++;
    if ({req_ready, mem_rd_req, mem_rd_addr, ram_addr, ram_en, ram_wen, ram_wdata, crit_valid,
         crit_data, refill_done, refill_way, refill_index, refill_err} !== {1'b1, 126'b0}) begin
      fails++;
      $display("FAIL reset_state: got ready=%b req=%b en=%b done=%b, required ready=1 rest 0",
               req_ready, mem_rd_req, ram_en, refill_done);
    end
    rst = 1'b0;
    tick();
    req_addr = 32'h0000_2468; req_way = 1'b1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; mem_rd_ack = 1'b1;
    tick();
    mem_rd_ack = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mem_rd_valid = 1'b1; mem_rd_data = 32'h1000_0000 + 32'(b);
      exp_q.push_back('{{9'h123, 3'(3'd2 + 3'(b))}, 32'h1000_0000 + 32'(b), 2'b10});
      tick();
    end
    mem_rd_valid = 1'b1; mem_rd_data = 32'hCAFE_F00D;
    #1;
    rst = 1'b1;
    #1;
    tests++;
    if ({req_ready, mem_rd_req, mem_rd_addr, ram_addr, ram_en, ram_wen, ram_wdata, crit_valid,
         crit_data, refill_done, refill_way, refill_index, refill_err} !== {1'b1, 126'b0}) begin
      fails++;
      $display("FAIL reset_mid_fill: got ready=%b en=%b wdata=%h done=%b, required ready=1 rest 0",
               req_ready, ram_en, ram_wdata, refill_done);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL partial_writes: got %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    d0 = done_seen;
    mem_rd_valid = 1'b0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    tests++;
    if (done_seen != d0) begin
      fails++;
      $display("FAIL reset_no_done: got %0d done pulses, required 0", done_seen - d0);
    end
    do_miss(32'h0000_2468, 1'b0, 0, 0, 7, 1'b0);
  endtask

  task automatic test_crit_wrap();
    do_miss(32'h0000_1234, 1'b1, 0, 0, 7, 1'b0);
  endtask

  task automatic test_gapped();
    do_miss(32'h0008_4000, 1'b0, 0, 2, 7, 1'b0);
  endtask

  task automatic test_ack_delay();
    do_miss(32'hFFFF_FFFC, 1'b1, 5, 0, 7, 1'b0);
  endtask

  task automatic test_last_errors();
    do_miss(32'h0000_0A38, 1'b0, 1, 0, 3, 1'b1);
    do_miss(32'h0000_0A38, 1'b1, 0, 1, -1, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_miss(32'h0000_5550, 1'b0, 0, 0, 7, 1'b0);
    do_miss(32'h0000_5544, 1'b1, 0, 0, 7, 1'b0);
  endtask

  initial begin
    test_reset();
    test_crit_wrap();
    test_gapped();
    test_ack_delay();
    test_last_errors();
    test_back_to_back();
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
